// File: rtl/servo_pkg.sv
// Shared types, constants and the slew rule for the servo command sequencer.
package servo_pkg;
  localparam int VALUE_W              = 10;
  localparam int DEFAULT_FRAME_CYCLES = 333500;

  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_e;

  // One frame of slewing: off is immediate, first enable jumps, otherwise move by <= step.
  function automatic logic [VALUE_W-1:0] servo_slew(input logic [VALUE_W-1:0] c,
                                                    input logic [VALUE_W-1:0] t,
                                                    input logic [VALUE_W-1:0] step);
    logic [VALUE_W:0]   c11, t11, s11, diff;
    logic [VALUE_W-1:0] r;
    c11  = {1'b0, c};
    t11  = {1'b0, t};
    s11  = {1'b0, step};
    diff = (t11 > c11) ? t11 - c11 : c11 - t11;
    if (t == '0)          r = '0;
    else if (c == '0)     r = t;
    else if (diff <= s11) r = t;
    else if (t11 > c11)   r = VALUE_W'(c11 + s11);
    else                  r = VALUE_W'(c11 - s11);
    return r;
  endfunction
endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; FRAME is a registered one-cycle pulse per wrap.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  output logic FRAME
);
  localparam logic [18:0] LAST = 19'(FRAME_CYCLES - 1);

  logic [18:0] cnt_q;
  logic        frame_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= (cnt_q == LAST);
      cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 19'd1;
    end
  end

  assign FRAME = frame_q;
endmodule

// File: rtl/servo_sequencer.sv
// Multi-channel servo command front end: latches per-channel targets and,
// once per frame, slews each channel's output toward its target.
module servo_sequencer
  import servo_pkg::*;
#(
  parameter int N_CHAN       = 4,
  parameter int CHAN_W       = 2,
  parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
  parameter int STEP         = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [CHAN_W-1:0]         CMD_CHAN,
  input  logic [VALUE_W-1:0]        CMD_VALUE,
  output logic [VALUE_W*N_CHAN-1:0] VALUES,
  output logic                      FRAME,
  output logic                      BUSY
);
  localparam logic [VALUE_W-1:0] STEP_V   = VALUE_W'(STEP);
  localparam logic [CHAN_W-1:0]  LAST_IDX = CHAN_W'(N_CHAN - 1);

  state_e                           state_q;
  logic [CHAN_W-1:0]                idx_q;
  logic                             ready_q, busy_q;
  logic [N_CHAN-1:0][VALUE_W-1:0]   tgt_q, cur_q;
  logic [N_CHAN-1:0]                mism;
  logic                             frame;
  logic                             accept;

  servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .FRAME(frame)
  );

  assign accept = CMD_VALID && ready_q;

  always_comb begin
    mism = '0;
    for (int k = 0; k < N_CHAN; k++) mism[k] = (tgt_q[k] != cur_q[k]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      tgt_q   <= '0;
      cur_q   <= '0;
    end else begin
      busy_q <= |mism;
      // Out-of-range channel indices match no k and are silently dropped.
      for (int k = 0; k < N_CHAN; k++)
        if (accept && CMD_CHAN == CHAN_W'(k)) tgt_q[k] <= CMD_VALUE;
      case (state_q)
        ST_IDLE: begin
          if (frame) begin
            state_q <= ST_SWEEP;
            idx_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SWEEP: begin
          for (int k = 0; k < N_CHAN; k++)
            if (idx_q == CHAN_W'(k)) cur_q[k] <= servo_slew(cur_q[k], tgt_q[k], STEP_V);
          if (idx_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + CHAN_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CMD_READY = ready_q;
  assign VALUES    = cur_q;
  assign FRAME     = frame;
  assign BUSY      = busy_q;
endmodule

// File: tb/tb_servo_sequencer.sv
// Scoreboard bench: stimulus queues per-frame expectations, a monitor checks each sweep.
module tb_servo_sequencer;
  import servo_pkg::*;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int FC = 100;
  localparam int ST = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            CMD_VALID = 1'b0;
  logic            CMD_READY, FRAME, BUSY;
  logic [CW-1:0]   CMD_CHAN = '0;
  logic [9:0]      CMD_VALUE = '0;
  logic [N*10-1:0] VALUES;

  // busy bit m is the required BUSY in cycle f+2+m for a FRAME in cycle f
  typedef struct packed {
    logic [N-1:0][9:0] v;
    logic [4:0]        busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  bit   mon_en = 1'b1;
  int   n, w;

  servo_sequencer #(.N_CHAN(N), .CHAN_W(CW), .FRAME_CYCLES(FC), .STEP(ST)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_CHAN (CMD_CHAN),
    .CMD_VALUE(CMD_VALUE),
    .VALUES   (VALUES),
    .FRAME    (FRAME),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input int b, input int c, input int d, input logic [4:0] bz);
    exp_t e;
    e.v[0] = 10'(a); e.v[1] = 10'(b); e.v[2] = 10'(c); e.v[3] = 10'(d);
    e.busy = bz;
    sb.push_back(e);
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!FRAME && k < 300);
    if (!FRAME) chk("frame_timeout", 0, 1);
  endtask

  task automatic send(input int ch, input int val, output int waited);
    CMD_VALID = 1'b1;
    CMD_CHAN  = CW'(ch);
    CMD_VALUE = 10'(val);
    waited = 0;
    while (!CMD_READY && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 50) chk("send_timeout", 0, 1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic after_sweep();
    repeat (7) @(negedge CLK);
  endtask

  // Monitor: each FRAME pops one expectation and follows the sweep cycle by cycle.
  initial forever begin
    @(negedge CLK);
    if (FRAME && mon_en) begin
      if (sb.size() == 0) chk("sb_underflow", 0, 1);
      else begin
        mon_e = sb.pop_front();
        @(negedge CLK);
        chk("frame_width", FRAME, 0);
        chk("ready_f1", CMD_READY, 0);
        for (int j = 0; j < 5; j++) begin
          @(negedge CLK);
          if (j < N) chk($sformatf("ch%0d_value", j), VALUES[j*10 +: 10], mon_e.v[j]);
          chk($sformatf("busy_f%0d", j + 2), BUSY, mon_e.busy[j]);
          chk($sformatf("ready_f%0d", j + 2), CMD_READY, (j >= 3) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    // Reset release, first enable of ch1 ahead of the first frame
    push(0, 500, 0, 0, 5'b00011);
    repeat (5) @(negedge CLK);
    chk("rst_values", VALUES, 0);
    chk("rst_ready", CMD_READY, 0);
    chk("rst_frame", FRAME, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1'b0;
    n = 0;
    @(negedge CLK); n++;
    chk("ready_after_rst", CMD_READY, 1);
    CMD_VALID = 1'b1; CMD_CHAN = 3'd1; CMD_VALUE = 10'd500;
    @(negedge CLK); n++;
    CMD_VALID = 1'b0;
    while (!FRAME && n < 300) begin
      @(negedge CLK); n++;
    end
    chk("first_frame_cycles", n, FC);
    after_sweep();

    // Slew up ch1 500->510 while ch2 enables at 300
    push(0, 504, 300, 0, 5'b11111);
    send(1, 510, w);
    send(2, 300, w);
    wait_frame(); after_sweep();
    push(0, 508, 304, 0, 5'b11111);
    send(2, 900, w);
    wait_frame(); after_sweep();
    // ch2 disabled mid-ramp drops straight to 0
    push(0, 510, 0, 0, 5'b00111);
    send(2, 0, w);
    wait_frame(); after_sweep();
    // Reverse slew 510->490
    push(0, 506, 0, 0, 5'b11111);
    send(1, 490, w);
    wait_frame(); after_sweep();

    // Command held across a sweep waits for the first IDLE cycle
    push(0, 502, 0, 0, 5'b11111);
    wait_frame();
    @(negedge CLK);
    send(3, 200, w);
    chk("sweep_stall_cycles", w, N);
    push(0, 498, 0, 200, 5'b11111);
    wait_frame(); after_sweep();

    // Command in the FRAME cycle lands in that sweep
    push(100, 494, 0, 200, 5'b11111);
    wait_frame();
    send(0, 100, w);
    chk("frame_cycle_accept_wait", w, 0);
    after_sweep();

    // Out-of-range channel has no effect
    push(100, 490, 0, 200, 5'b00011);
    send(5, 777, w);
    wait_frame(); after_sweep();

    // Reset in the middle of a sweep
    send(2, 600, w);
    mon_en = 1'b0;
    wait_frame();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_values", VALUES, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_frame", FRAME, 0);
    chk("midrst_ready", CMD_READY, 0);
    RST = 1'b0;
    push(0, 0, 0, 0, 5'b00000);
    mon_en = 1'b1;
    n = 0;
    @(negedge CLK); n++;
    chk("midrst_idle", CMD_READY, 1);
    while (!FRAME && n < 300) begin
      @(negedge CLK); n++;
    end
    chk("midrst_frame_cycles", n, FC);
    after_sweep();

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/servo_sequencer.md
Name: servo_sequencer

Overview:
- Multi-channel command front end for the Servo PWM blocks; drives one 10-bit VALUE per channel.
- Accepts position commands over a valid/ready handshake and stores a per-channel target.
- Once per servo frame, slews each channel's output toward its target by at most STEP units.
- Sits between the host/command decoder and N_CHAN Servo instances, so servos never jump across their full range.

Parameters:
- N_CHAN, 4, number of servo channels (2..16).
- CHAN_W, 2, width of the channel index; must satisfy 2^CHAN_W >= N_CHAN.
- FRAME_CYCLES, 333500, CLK cycles per servo frame; same period as the Servo PWM frame.
- STEP, 4, maximum change in VALUE per frame (1..1023).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command this cycle.
- CMD_CHAN  in  CHAN_W  target channel.
- CMD_VALUE  in  10  target position; 0 means channel off.
- VALUES  out  10*N_CHAN  current position per channel; channel k is at bits [10k+9:10k]; feeds Servo VALUE inputs.
- FRAME  out  1  one-cycle pulse at each frame boundary.
- BUSY  out  1  high while any channel's current value differs from its target.

Behaviour:
- All logic runs on the rising edge of CLK. RST is sampled synchronously and has priority over everything else.
- Reset state: frame counter 0; all targets and currents 0 (VALUES = 0, so the servos output no PWM); FSM in IDLE; FRAME 0; BUSY 0; CMD_READY 0 while RST is high.
- Reset asserted mid-sweep: abandon the sweep and zero everything on the next edge. No partial updates survive.
- Frame timer:
  - 19-bit counter runs 0..FRAME_CYCLES-1 and wraps to 0.
  - FRAME is registered and is high for the one cycle after the counter equals FRAME_CYCLES-1.
  - First FRAME pulse appears FRAME_CYCLES cycles after RST deasserts.
- Handshake:
  - CMD_READY = 1 exactly when the FSM is in IDLE.
  - A transfer occurs when CMD_VALID && CMD_READY; target[CMD_CHAN] <= CMD_VALUE on that edge.
  - A channel index >= N_CHAN is accepted and dropped.
  - A later command to the same channel overwrites the earlier one. No queueing.
  - CMD_VALID may stay high while CMD_READY is low; the command is taken on the first ready cycle.
- FSM states: IDLE and SWEEP, with index register idx.
  - IDLE -> SWEEP when FRAME = 1; idx <= 0.
  - A command accepted in the same cycle as FRAME is written, and the sweep sees the new target.
  - In SWEEP, one channel is updated per cycle; idx increments; after idx = N_CHAN-1 the FSM returns to IDLE.
  - The sweep lasts exactly N_CHAN cycles and CMD_READY is low throughout.
  - Requirement: N_CHAN < FRAME_CYCLES, so a sweep always finishes before the next FRAME.
- Slew rule for channel idx, with current value c and target t:
  - If t == 0: c <= 0 immediately (disable is never ramped).
  - Else if c == 0: c <= t (first enable jumps straight to target, since 0 is the off code).
  - Else if |t - c| <= STEP: c <= t.
  - Else: c <= c + STEP when t > c, or c - STEP when t < c.
  - Arithmetic is done at 11 bits, so no wrap-around below 0 or above 1023.
- Latency: for the FRAME pulse in cycle f, channel k's new VALUES are visible in cycle f+2+k.
- BUSY is registered and reflects the targets/currents of the previous cycle.

Decomposition:
- Package servo_pkg holds:
  - VALUE_W = 10
  - DEFAULT_FRAME_CYCLES = 333500
  - the FSM state encoding (IDLE, SWEEP)
  - a function servo_slew(c, t, step) returning the next current value, used by the RTL and the bench model.
- Sub-module servo_frame_timer (CLK, RST, FRAME_CYCLES parameter) produces the FRAME pulse.
- Target and current arrays stay inside servo_sequencer.

Test Plan (sim with FRAME_CYCLES = 100, N_CHAN = 4, STEP = 4):
- Reset release: hold RST 5 cycles then release. Required: VALUES = 0, CMD_READY = 1 next cycle, first FRAME 100 cycles after release, FRAME pulse width 1.
- First enable: cmd ch1 = 500. At the next FRAME, ch1 = 500 visible at f+3; BUSY falls the following cycle; ch0/2/3 stay 0.
- Slew: ch1 at 500, cmd ch1 = 510. Next frames give 504, 508, 510, then it holds; BUSY stays high until 510 is reached. Reverse with cmd ch1 = 490: 506, 502, 498, 494, 490.
- Disable: ch2 at 300 ramping to 900, cmd ch2 = 0. At the next sweep ch2 = 0 (no ramp).
- Handshake/collision: hold CMD_VALID with ch3 = 200 so it is presented during a sweep. Required: CMD_READY low for exactly 4 cycles, command accepted on the first IDLE cycle. Separately, a command in the FRAME cycle is applied in that same sweep. A CMD_CHAN out of range has no effect.
- Mid-sweep reset: assert RST at f+2. Required: all VALUES = 0 and the FSM in IDLE next cycle, and the frame counter restarts from 0.
